// File: rtl/count_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// count_arbiter_pkg
// Shared definitions for the count_arbiter block: arbiter FSM state encoding,
// requester index constants and the number of requesters.
// -----------------------------------------------------------------------------
package count_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int REQ0    = 0;
    localparam int REQ1    = 1;

endpackage : count_arbiter_pkg

// File: rtl/count_core.sv
// -----------------------------------------------------------------------------
// count_core
// The shared WIDTH-bit up/down count register. Steps by one when step_en is
// high, in the direction given by up.
//
// Optional feature: define COUNT_SAT_EN to make the count saturate at all-ones
// (going up) and zero (going down) instead of wrapping modulo 2^WIDTH.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   step_en  in   perform one step this cycle
//   up       in   1 = increment, 0 = decrement
//   count    out  current count value (registered)
//   sat      out  the requested step is being blocked by saturation this cycle
//                 (always 0 without COUNT_SAT_EN)
// -----------------------------------------------------------------------------
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] r_count;
    logic             w_blocked;

`ifdef COUNT_SAT_EN
    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // A step is blocked when it would cross the end of the range.
    assign w_blocked = up ? (r_count == COUNT_MAX) : (r_count == '0);
`else
    assign w_blocked = 1'b0;
`endif

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (step_en && !w_blocked) begin
            r_count <= up ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign sat   = step_en & w_blocked;

endmodule : count_core

// File: rtl/count_arbiter.sv
// -----------------------------------------------------------------------------
// count_arbiter
// Round-robin controller sharing one up/down count register (count_core)
// between two requesters. A granted requester gets a burst of len single steps
// in its latched direction, followed by a one-cycle done pulse.
//
// Optional feature: COUNT_SAT_EN (see count_core) makes the count saturate and
// enables the sticky sat_hit flag; without it sat_hit is constant 0.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   [1:0] request per requester, held until that requester's done
//   dir      in   [1:0] per-requester direction (1 = up), sampled at grant
//   len0     in   [LEN_W-1:0] requester 0 burst length, sampled at grant
//   len1     in   [LEN_W-1:0] requester 1 burst length, sampled at grant
//   gnt      out  [1:0] one-hot grant, held from grant through the DONE cycle
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse ending a burst
//   count    out  [WIDTH-1:0] current count value
//   sat_hit  out  sticky per burst: a step was blocked by saturation
// -----------------------------------------------------------------------------
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic             sat_hit
);

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       r_ptr;          // requester favoured on a tie
    logic                       r_cur_dir;
    logic [LEN_W-1:0]           r_remaining;
    logic [NUM_REQ-1:0]         r_gnt;
    logic                       r_sat_hit;

    logic                       w_grant_valid;
    logic                       w_grant_idx;
    logic [LEN_W-1:0]           w_grant_len;
    logic                       w_grant_dir;
    logic                       w_step_en;
    logic                       w_sat;

    // ---------------------------------------------------------------------
    // Grant selection (only consumed in IDLE)
    // ---------------------------------------------------------------------
    assign w_grant_valid = |req;

    always_comb begin
        // With a single request, req[REQ1] alone names the requester.
        if (req == 2'b11) begin
            w_grant_idx = r_ptr;
        end else begin
            w_grant_idx = req[REQ1];
        end
    end

    assign w_grant_len = (int'(w_grant_idx) == REQ1) ? len1 : len0;
    assign w_grant_dir = dir[w_grant_idx];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    // A zero-length burst skips RUN entirely.
                    w_next_state = (w_grant_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (r_remaining == LEN_W'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output decode (from registered state only)
    // ---------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        w_step_en = 1'b0;
        unique case (r_state)
            RUN: begin
                busy      = 1'b1;
                w_step_en = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Burst bookkeeping: grant, latched command, round-robin pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt       <= '0;
            r_cur_dir   <= 1'b0;
            r_remaining <= '0;
            r_sat_hit   <= 1'b0;
            r_ptr       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt       <= NUM_REQ'(1) << w_grant_idx;
                        r_cur_dir   <= w_grant_dir;
                        r_remaining <= w_grant_len;
                        r_sat_hit   <= 1'b0;
                    end
                end
                RUN: begin
                    // A blocked step still consumes one unit of the burst.
                    r_remaining <= r_remaining - 1'b1;
                    if (w_sat) begin
                        r_sat_hit <= 1'b1;
                    end
                end
                DONE: begin
                    r_gnt <= '0;
                    // Hand the tie-break to whichever requester was not served.
                    r_ptr <= ~r_gnt[REQ1];
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Shared count register
    // ---------------------------------------------------------------------
    count_core #(
        .WIDTH   (WIDTH)
    ) u_count_core (
        .clk     (clk),
        .reset_n (reset_n),
        .step_en (w_step_en),
        .up      (r_cur_dir),
        .count   (count),
        .sat     (w_sat)
    );

    assign gnt     = r_gnt;
    // Without COUNT_SAT_EN, w_sat is constant 0 so this register never sets.
    assign sat_hit = r_sat_hit;

endmodule : count_arbiter

// File: tb/tb_count_arbiter.sv
// -----------------------------------------------------------------------------
// tb_count_arbiter
// Directed bench for count_arbiter. Expected per-cycle outputs are pushed to a
// scoreboard queue as each stimulus step is driven, then popped and compared
// one time unit after the following rising edge. A small count model (wrap or,
// with COUNT_SAT_EN, saturate) supplies the expected count and sat_hit.
// -----------------------------------------------------------------------------
module tb_count_arbiter;

    localparam int WIDTH = 4;
    localparam int LEN_W = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;
    logic             sat_hit;

    count_arbiter #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .dir     (dir),
        .len0    (len0),
        .len1    (len1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .sat_hit (sat_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       gnt;
        logic             busy;
        logic             done;
        logic [WIDTH-1:0] count;
        logic             sat_hit;
    } obs_t;

    obs_t             sb_q[$];
    string            tag_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] m_count;
    logic             m_sat;

    task automatic expect_push(input string tag, input logic [1:0] g,
                               input logic b, input logic d);
        obs_t e;
        e.gnt     = g;
        e.busy    = b;
        e.done    = d;
        e.count   = m_count;
        e.sat_hit = m_sat;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_head();
        obs_t  e;
        obs_t  o;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o.gnt     = gnt;
        o.busy    = busy;
        o.done    = done;
        o.count   = count;
        o.sat_hit = sat_hit;
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed gnt=%b busy=%b done=%b count=%0d sat_hit=%b, expected gnt=%b busy=%b done=%b count=%0d sat_hit=%b",
                   t, o.gnt, o.busy, o.done, o.count, o.sat_hit,
                   e.gnt, e.busy, e.done, e.count, e.sat_hit);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Reference count step: modulo wrap, or clamp with COUNT_SAT_EN.
    task automatic model_step(input logic up);
`ifdef COUNT_SAT_EN
        if ((up && m_count == '1) || (!up && m_count == '0)) begin
            m_sat = 1'b1;
        end else begin
            m_count = up ? WIDTH'(m_count + 1) : WIDTH'(m_count - 1);
        end
`else
        m_count = up ? WIDTH'(m_count + 1) : WIDTH'(m_count - 1);
`endif
    endtask

    // Reset is asserted off-edge; checked immediately (asynchronous) and
    // again after an edge with reset still held (no done may appear).
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        req     = 2'b00;
        m_count = '0;
        m_sat   = 1'b0;
        #1;
        expect_push({tag, "_async"}, 2'b00, 1'b0, 1'b0);
        compare_head();
        expect_push({tag, "_held"}, 2'b00, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    // Caller has driven req/dir/len with the DUT in IDLE; the next edge is the
    // sampling edge. Checks n RUN cycles, the DONE cycle and the IDLE cycle.
    // drop_at in 1..n: after checking that RUN cycle, drop req and scramble
    // dir/len. drop_at = n+1: drop req after the DONE cycle. Otherwise hold.
    task automatic burst(input string tag, input int idx, input logic up,
                         input int n, input int drop_at);
        logic [1:0] g;
        g     = 2'b01 << idx;
        m_sat = 1'b0;
        for (int k = 1; k <= n; k++) begin
            expect_push({tag, "_run"}, g, 1'b1, 1'b0);
            tick();
            if (k == drop_at) begin
                req  = 2'b00;
                dir  = ~dir;
                len0 = '0;
                len1 = '1;
            end
            model_step(up);
        end
        expect_push({tag, "_done"}, g, 1'b1, 1'b1);
        tick();
        if (drop_at == n + 1) begin
            req = 2'b00;
        end
        expect_push({tag, "_idle"}, 2'b00, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        req     = 2'b00;
        dir     = 2'b00;
        len0    = '0;
        len1    = '0;
        m_count = '0;
        m_sat   = 1'b0;
        #3;
        do_reset("reset");

        // Requester 0, up, len 5: count 0 -> 5, done six cycles after sampling.
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd5;
        burst("up5", 0, 1'b1, 5, 6);

        // Bring count to 14, then an up burst of 3 across the top.
        req  = 2'b01;
        len0 = 4'd9;
        burst("up9", 0, 1'b1, 9, 10);
        req  = 2'b01;
        len0 = 4'd3;
        burst("wrap_up3", 0, 1'b1, 3, 4);

        // Reset mid-burst once count has reached 3.
        do_reset("rst2");
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd6;
        m_sat = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_push("pre_abort_run", 2'b01, 1'b1, 1'b0);
            tick();
            model_step(1'b1);
        end
        #2;
        do_reset("abort");
        expect_push("post_abort_idle", 2'b00, 1'b0, 1'b0);
        tick();

        // Both requesting: REQ0, REQ1, REQ0 with one IDLE cycle between.
        req  = 2'b11;
        dir  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd2;
        burst("rr_a", 0, 1'b1, 2, -1);
        burst("rr_b", 1, 1'b1, 2, -1);
        burst("rr_c", 0, 1'b1, 2, 3);

        // Zero-length burst on requester 1.
        req  = 2'b10;
        dir  = 2'b00;
        len1 = 4'd0;
        burst("zero_len", 1, 1'b0, 0, 1);

        // Down burst of 4 from 2; requester drops req after the first step.
        do_reset("rst3");
        req  = 2'b01;
        dir  = 2'b01;
        len0 = 4'd2;
        burst("to_two", 0, 1'b1, 2, 3);
        req  = 2'b10;
        dir  = 2'b00;
        len1 = 4'd4;
        burst("drop_down4", 1, 1'b0, 4, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_count_arbiter
